// File: rtl/pn_excite_seq.sv
// pn_excite_seq: drives P/N excitation for a bank of PN flip-flops through a queue of targets.
// Latency: a target accepted at edge k is on P/N for cycle k+1..k+2; q_model follows at edge k+2.
// Backpressure: tgt_ready low when the target FIFO is full or in reset; step_en paces the drives.
//
// Optional feature macro: PN_CHECK_EN (adds q_obs checking, sticky err and mis_cnt[7:0]).
// Ports:
//   Clk, rst (async active-low)   clock / reset
//   tgt_valid, tgt_data, tgt_ready target stream into the FIFO
//   step_en, flush                 drive pacing and synchronous queue drop
//   P, N, q_model, busy            registered excitation, model of bank state, activity flag
//   q_obs, err [, mis_cnt]         observed bank state and mismatch reporting
module pn_excite_seq #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  parameter int MODE  = 0
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  input  logic             step_en,
  input  logic             flush,
  output logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] N,
  output logic [WIDTH-1:0] q_model,
  output logic             busy,
  input  logic [WIDTH-1:0] q_obs,
`ifdef PN_CHECK_EN
  output logic [7:0]       mis_cnt,
`endif
  output logic             err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, DRIVE} state_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d, n_q, n_d, qm_q, qm_d, drv_q, drv_d;
  logic [WIDTH-1:0] head, base;
  logic             push, pop, empty, full;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign tgt_ready = rst & ~full;
  // A full FIFO refuses the push even if the same edge pops; flush discards it.
  assign push      = tgt_valid & tgt_ready & ~flush;
  // Same start condition in IDLE and DRIVE: DRIVE lasts one cycle, so every
  // DRIVE edge is the edge that decides whether to chain another step.
  assign pop       = ~empty & step_en & ~flush;
  assign head      = mem_q[rd_ptr_q];
  // Excitation is relative to the state the bank will hold after the current step.
  assign base      = (state_q == DRIVE) ? drv_q : qm_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    qm_d     = qm_q;
    drv_d    = drv_q;
    state_d  = IDLE;
    p_d      = '0;
    n_d      = '1;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end

    if (state_q == DRIVE) qm_d = drv_q;

    if (pop) begin
      state_d = DRIVE;
      drv_d   = head;
      if (MODE == 0) begin
        p_d = base ^ head;
        n_d = ~(base ^ head);
      end else begin
        p_d = head;
        n_d = head;
      end
    end
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      p_q      <= '0;
      n_q      <= '1;
      qm_q     <= '0;
      drv_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      p_q      <= p_d;
      n_q      <= n_d;
      qm_q     <= qm_d;
      drv_q    <= drv_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= tgt_data;
  end

  assign P       = p_q;
  assign N       = n_q;
  assign q_model = qm_q;
  assign busy    = (state_q == DRIVE) | ~empty;

`ifdef PN_CHECK_EN
  // chk_q marks the cycle after a DRIVE completed; q_model already holds the target then.
  logic       chk_q, err_q;
  logic [7:0] mis_q;

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      chk_q <= 1'b0;
      err_q <= 1'b0;
      mis_q <= '0;
    end else begin
      chk_q <= (state_q == DRIVE);
      if (chk_q && (q_obs != qm_q)) begin
        err_q <= 1'b1;
        if (mis_q != 8'hFF) mis_q <= mis_q + 1'b1;
      end
    end
  end

  assign err     = err_q;
  assign mis_cnt = mis_q;
`else
  logic unused_q_obs;
  assign unused_q_obs = ^q_obs;
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_pn_excite_seq.sv
// tb_pn_excite_seq: checks two pn_excite_seq instances (MODE 0 and MODE 1) sharing one stimulus.
// Latency: outputs compared every cycle at the falling edge against a queue-based reference.
// Backpressure: acceptance is predicted from the reference queue occupancy.
module tb_pn_excite_seq;

  logic       Clk = 1'b0;
  logic       rst;
  logic       tgt_valid, step_en, flush;
  logic [1:0] tgt_data, q_obs;
  logic [1:0] p0, n0, qm0, p1, n1, qm1;
  logic       rdy0, rdy1, busy0, busy1, err0, err1;
`ifdef PN_CHECK_EN
  logic [7:0] mis0, mis1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  pn_excite_seq #(.WIDTH(2), .DEPTH(4), .MODE(0)) dut0 (
    .Clk(Clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_ready(rdy0),
    .step_en(step_en), .flush(flush), .P(p0), .N(n0), .q_model(qm0), .busy(busy0),
    .q_obs(q_obs),
`ifdef PN_CHECK_EN
    .mis_cnt(mis0),
`endif
    .err(err0));

  pn_excite_seq #(.WIDTH(2), .DEPTH(4), .MODE(1)) dut1 (
    .Clk(Clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_ready(rdy1),
    .step_en(step_en), .flush(flush), .P(p1), .N(n1), .q_model(qm1), .busy(busy1),
    .q_obs(q_obs),
`ifdef PN_CHECK_EN
    .mis_cnt(mis1),
`endif
    .err(err1));

  // Reference: a queue of pending targets, the target currently on P/N (if any),
  // and the PN bank state the design should believe in.
  logic [1:0] mq[$];
  bit         m_drv, m_chk, m_err;
  logic [1:0] m_drvt, m_qm, m_p0, m_n0, m_p1, m_n1;
  int         m_mis;
  bit         obs_force = 1'b0;
  logic [1:0] obs_val   = 2'b00;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic model_reset();
    mq.delete();
    m_drv = 0; m_drvt = 2'b00; m_qm = 2'b00;
    m_p0 = 2'b00; m_n0 = 2'b11; m_p1 = 2'b00; m_n1 = 2'b11;
    m_chk = 0; m_err = 0; m_mis = 0;
  endtask

  task automatic model_step(input bit v, input logic [1:0] d, input bit s, input bit f);
    bit         can_take, start;
    logic [1:0] from, head;
    can_take = (mq.size() < 4);
    start    = (mq.size() > 0) && s && !f;
    from     = m_drv ? m_drvt : m_qm;
    if (m_chk && (q_obs != m_qm)) begin
      m_err = 1;
      if (m_mis < 255) m_mis++;
    end
    m_chk = m_drv;
    if (m_drv) m_qm = m_drvt;
    if (start) begin
      head = mq.pop_front();
      for (int b = 0; b < 2; b++) begin
        if (head[b] == from[b]) begin m_p0[b] = 1'b0; m_n0[b] = 1'b1; end
        else                    begin m_p0[b] = 1'b1; m_n0[b] = 1'b0; end
      end
      m_p1 = head; m_n1 = head;
      m_drv = 1; m_drvt = head;
    end else begin
      m_p0 = 2'b00; m_n0 = 2'b11; m_p1 = 2'b00; m_n1 = 2'b11;
      m_drv = 0;
    end
    if (f) mq.delete();
    else if (v && can_take) mq.push_back(d);
  endtask

  task automatic check_model();
    bit exp_busy, exp_rdy;
    exp_busy = m_drv || (mq.size() != 0);
    exp_rdy  = rst && (mq.size() < 4);
    chk("m0_P", p0, m_p0);   chk("m0_N", n0, m_n0);
    chk("m1_P", p1, m_p1);   chk("m1_N", n1, m_n1);
    chk("m0_q", qm0, m_qm);  chk("m1_q", qm1, m_qm);
    chk("m0_busy", busy0, exp_busy); chk("m1_busy", busy1, exp_busy);
    chk("m0_ready", rdy0, exp_rdy);  chk("m1_ready", rdy1, exp_rdy);
`ifdef PN_CHECK_EN
    chk("m_err", err0, m_err);  chk("m_mis", mis0, m_mis);
`else
    chk("m_err", err0, 0);
`endif
  endtask

  // Called right after a falling edge: apply inputs, advance reference, check next falling edge.
  task automatic cycle(input bit v, input logic [1:0] d, input bit s, input bit f);
    tgt_valid = v; tgt_data = d; step_en = s; flush = f;
    q_obs = obs_force ? obs_val : m_qm;
    if (rst) model_step(v, d, s, f);
    else     model_reset();
    @(posedge Clk);
    @(negedge Clk);
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    cycle(0, 2'b00, 0, 0);
    cycle(0, 2'b00, 0, 0);
    rst = 1'b1;
  endtask

  typedef struct {
    bit         v;
    logic [1:0] d;
    logic [1:0] p, n, q;
    bit         busy;
  } vec_t;

  vec_t       tbl[6];
  logic [1:0] w3[5];
  int         idx;

  initial begin
    tbl[0] = '{1'b1, 2'b01, 2'b00, 2'b11, 2'b00, 1'b1};
    tbl[1] = '{1'b1, 2'b11, 2'b01, 2'b10, 2'b00, 1'b1};
    tbl[2] = '{1'b1, 2'b10, 2'b10, 2'b01, 2'b01, 1'b1};
    tbl[3] = '{1'b1, 2'b00, 2'b01, 2'b10, 2'b11, 1'b1};
    tbl[4] = '{1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b1};
    tbl[5] = '{1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0};

    tgt_valid = 0; tgt_data = 0; step_en = 0; flush = 0; q_obs = 0;
    rst = 1'b0;
    model_reset();
    @(negedge Clk);
    do_reset();
    chk("reset_P", p0, 2'b00);
    chk("reset_N", n0, 2'b11);

    // Back-to-back steps through four targets.
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].v, tbl[i].d, 1'b1, 1'b0);
      chk("t1_P", p0, tbl[i].p);
      chk("t1_N", n0, tbl[i].n);
      chk("t1_q", qm0, tbl[i].q);
      chk("t1_busy", busy0, tbl[i].busy);
    end

    // Set/clear encoding: P = N = target.
    cycle(1, 2'b10, 1, 0);
    cycle(1, 2'b01, 1, 0);
    chk("t2_P1a", p1, 2'b10); chk("t2_N1a", n1, 2'b10);
    cycle(0, 2'b00, 1, 0);
    chk("t2_P1b", p1, 2'b01); chk("t2_N1b", n1, 2'b01);
    cycle(0, 2'b00, 1, 0);
    chk("t2_q", qm1, 2'b01);

    // Fill to full with step_en low, then release.
    w3[0] = 2'b11; w3[1] = 2'b00; w3[2] = 2'b01; w3[3] = 2'b11; w3[4] = 2'b10;
    idx = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1, w3[idx], 0, 0);
      idx++;
    end
    chk("t3_full_ready", rdy0, 1'b0);
    cycle(1, w3[4], 0, 0);
    chk("t3_held_ready", rdy0, 1'b0);
    cycle(1, w3[4], 1, 0);
    chk("t3_pop_ready", rdy0, 1'b1);
    cycle(1, w3[4], 1, 0);
    for (int i = 0; i < 6; i++) cycle(0, 2'b00, 1, 0);
    chk("t3_final_q", qm0, 2'b10);
    chk("t3_idle", busy0, 1'b0);

    // Flush during the first drive.
    cycle(1, 2'b11, 0, 0);
    cycle(1, 2'b01, 0, 0);
    cycle(1, 2'b00, 0, 0);
    cycle(0, 2'b00, 1, 0);
    cycle(0, 2'b00, 1, 1);
    chk("t4_busy", busy0, 1'b0);
    chk("t4_q", qm0, 2'b11);
    chk("t4_ready", rdy0, 1'b1);
    cycle(0, 2'b00, 1, 0);
    chk("t4_hold_P", p0, 2'b00);

    // Reset while busy with entries queued.
    cycle(1, 2'b01, 0, 0);
    cycle(1, 2'b10, 0, 0);
    cycle(1, 2'b00, 0, 0);
    cycle(0, 2'b00, 1, 0);
    rst = 1'b0;
    model_reset();
    #1;
    chk("t5_P", p0, 2'b00); chk("t5_N", n0, 2'b11);
    chk("t5_q", qm0, 2'b00); chk("t5_ready", rdy0, 1'b0);
    @(negedge Clk);
    cycle(0, 2'b00, 1, 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cycle(0, 2'b00, 1, 0);
    chk("t5_nodrive_P", p0, 2'b00);
    chk("t5_nodrive_busy", busy0, 1'b0);

`ifdef PN_CHECK_EN
    // Observed bank disagrees once, then agrees.
    obs_force = 1'b1; obs_val = 2'b10;
    cycle(1, 2'b11, 1, 0);
    cycle(0, 2'b00, 1, 0);
    cycle(0, 2'b00, 1, 0);
    cycle(0, 2'b00, 1, 0);
    chk("t6_err", err0, 1'b1);
    chk("t6_mis", mis0, 8'd1);
    obs_val = 2'b00;
    cycle(1, 2'b00, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 2'b00, 1, 0);
    chk("t6_err_sticky", err0, 1'b1);
    chk("t6_mis_keep", mis0, 8'd1);
    obs_force = 1'b0;
`endif

    // Random traffic, with rare flushes and resets.
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 99) != 0);
      cycle($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0);
    end
    rst = 1'b1;
    for (int i = 0; i < 8; i++) cycle(0, 2'b00, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
